// File: rtl/instruction_sequencer.sv
// Multi-cycle LEGv8 control sequencer: fetches into an instruction register and steps decoder micro-states.
// Optional PREFETCH_EN overlaps the next fetch with the retiring step.
module instruction_sequencer #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned MAX_STEPS   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   memRequest,
  input  logic                   memValid,
  input  logic [31:0]            memData,
  output logic [31:0]            instruction,
  output logic [1:0]             state,
  input  logic [1:0]             nextState,
  input  logic                   stall,
  output logic                   execValid,
  output logic [COUNT_WIDTH-1:0] instrCount,
  output logic                   stepError
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} phase_e;

  localparam logic [1:0] LAST_STEP = 2'(MAX_STEPS - 1);

  phase_e                 phase_q, phase_d;
  logic [31:0]            instr_q, instr_d;
  logic [1:0]             state_q, state_d;
  logic [1:0]             step_q, step_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   err_q, err_d;

  logic retire, abort, prefetch_hit;

  always_comb begin
    retire = (phase_q == EXEC) && !stall && (nextState == 2'd0);
    abort  = (phase_q == EXEC) && !stall && (nextState != 2'd0) && (step_q == LAST_STEP);
`ifdef PREFETCH_EN
    prefetch_hit = retire && memValid;
`else
    prefetch_hit = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) phase_q <= IDLE;
    else       phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      IDLE:    phase_d = FETCH;
      FETCH:   if (memValid) phase_d = EXEC;
      EXEC:    if ((retire && !prefetch_hit) || abort) phase_d = FETCH;
      default: phase_d = IDLE;
    endcase
  end

  always_comb begin
    execValid = (phase_q == EXEC);
`ifdef PREFETCH_EN
    memRequest = (phase_q == FETCH) || retire;
`else
    memRequest = (phase_q == FETCH);
`endif
  end

  always_comb begin
    instr_d = instr_q;
    state_d = state_q;
    step_d  = step_q;
    count_d = count_q;
    err_d   = err_q;
    if (phase_q == FETCH && memValid) begin
      instr_d = memData;
      state_d = 2'd0;
      step_d  = 2'd0;
    end else if (phase_q == EXEC && !stall) begin
      if (retire) begin
        count_d = count_q + COUNT_WIDTH'(1);
        state_d = 2'd0;
        if (prefetch_hit) begin
          instr_d = memData;
          step_d  = 2'd0;
        end
      end else if (abort) begin
        err_d   = 1'b1;
        state_d = 2'd0;
      end else begin
        state_d = nextState;
        step_d  = step_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= '0;
      state_q <= '0;
      step_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      state_q <= state_d;
      step_q  <= step_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign instruction = instr_q;
  assign state       = state_q;
  assign instrCount  = count_q;
  assign stepError   = err_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed plus randomized bench for instruction_sequencer against a transaction-level reference model.
module tb_instruction_sequencer;

  localparam int unsigned CW    = 4;
  localparam int unsigned STEPS = 4;
  localparam int unsigned CMASK = (1 << CW) - 1;
`ifdef PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          memRequest;
  logic          memValid = 1'b0;
  logic [31:0]   memData = '0;
  logic [31:0]   instruction;
  logic [1:0]    state;
  logic [1:0]    nextState = '0;
  logic          stall = 1'b0;
  logic          execValid;
  logic [CW-1:0] instrCount;
  logic          stepError;

  int total = 0;
  int bad   = 0;

  // Reference model: which activity is in progress, and how many steps the current instruction has advanced.
  bit          m_fetching, m_executing;
  logic [31:0] m_instr;
  int          m_state, m_advances, m_count;
  bit          m_err;
  bit          checking = 1'b0;

  instruction_sequencer #(.COUNT_WIDTH(CW), .MAX_STEPS(STEPS)) dut (
    .clock(clock), .reset(reset), .memRequest(memRequest), .memValid(memValid),
    .memData(memData), .instruction(instruction), .state(state), .nextState(nextState),
    .stall(stall), .execValid(execValid), .instrCount(instrCount), .stepError(stepError)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    if (reset) begin
      m_fetching = 0; m_executing = 0; m_instr = '0;
      m_state = 0; m_advances = 0; m_count = 0; m_err = 0;
    end else if (!m_fetching && !m_executing) begin
      m_fetching = 1;
    end else if (m_fetching) begin
      if (memValid) begin
        m_instr = memData; m_state = 0; m_advances = 0;
        m_fetching = 0; m_executing = 1;
      end
    end else if (!stall) begin
      if (nextState == 0) begin
        m_count = (m_count + 1) & CMASK;
        m_state = 0;
        if (PF && memValid) begin
          m_instr = memData; m_advances = 0;
        end else begin
          m_executing = 0; m_fetching = 1;
        end
      end else if (m_advances + 1 >= STEPS) begin
        m_err = 1; m_state = 0; m_executing = 0; m_fetching = 1;
      end else begin
        m_state = nextState;
        m_advances++;
      end
    end
  endfunction

  // Check every output before the edge, then advance DUT and model together.
  task automatic tick();
    bit exp_req;
    if (checking) begin
      exp_req = m_fetching || (PF && m_executing && !stall && nextState == 0);
      check("memRequest", 32'(memRequest), 32'(exp_req));
      check("execValid", 32'(execValid), 32'(m_executing));
      check("instruction", instruction, m_instr);
      check("state", 32'(state), 32'(m_state));
      check("instrCount", 32'(instrCount), 32'(m_count));
      check("stepError", 32'(stepError), 32'(m_err));
    end
    @(posedge clock);
    model_edge();
    checking = 1'b1;
    @(negedge clock);
  endtask

  task automatic fetch_word(input logic [31:0] w);
    int budget = 20;
    memValid = 1'b0;
    while (!m_fetching && budget > 0) begin
      tick();
      budget--;
    end
    total++;
    if (!m_fetching) begin
      bad++;
      $error("FAIL fetch_timeout observed=%0d expected=1", m_fetching);
    end
    memValid = 1'b1; memData = w;
    tick();
    memValid = 1'b0;
  endtask

  initial begin
    // 1: reset then ADDI
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick();
    nextState = 2'd0;
    fetch_word(32'h9100_0421);
    check("t1_instr", instruction, 32'h9100_0421);
    check("t1_exec", 32'(execValid), 32'd1);
    tick();
    check("t1_req", 32'(memRequest), 32'd1);
    check("t1_count", 32'(instrCount), 32'd1);

    // 2: three wait states
    repeat (3) tick();
    check("t2_req", 32'(memRequest), 32'd1);
    fetch_word(32'hD100_0842);
    check("t2_instr", instruction, 32'hD100_0842);
    tick();

    // 3: multi-step with stall
    fetch_word(32'hF840_0001);
    nextState = 2'd2; tick();
    stall = 1'b1; nextState = 2'd1; tick(); tick();
    stall = 1'b0; nextState = 2'd3; tick();
    check("t3_state", 32'(state), 32'd3);
    nextState = 2'd0; tick();
    check("t3_count", 32'(instrCount), 32'd3);

    // 4: watchdog
    fetch_word(32'hB400_0002);
    nextState = 2'd1;
    repeat (4) tick();
    check("t4_err", 32'(stepError), 32'd1);
    check("t4_state", 32'(state), 32'd0);
    check("t4_count", 32'(instrCount), 32'd3);
    nextState = 2'd0;
    fetch_word(32'h9100_0421); tick();
    check("t4_sticky", 32'(stepError), 32'd1);

    // 5: reset mid-EXEC at state 2 with count 5
    fetch_word(32'h9100_0421); tick();
    fetch_word(32'h9100_0421);
    nextState = 2'd2; tick();
    check("t5_pre_count", 32'(instrCount), 32'd5);
    check("t5_pre_state", 32'(state), 32'd2);
    reset = 1'b1; tick();
    check("t5_instr", instruction, 32'd0);
    check("t5_count", 32'(instrCount), 32'd0);
    check("t5_err", 32'(stepError), 32'd0);
    check("t5_req", 32'(memRequest), 32'd0);
    reset = 1'b0; nextState = 2'd0; tick();
    check("t5_req_after", 32'(memRequest), 32'd1);

    // 6: back-to-back single-step instructions with memory always ready
    memValid = 1'b1; memData = 32'h9100_0421; tick();
    memData = 32'h9100_0842; tick();
    memData = 32'h9100_0C63; tick();
    tick(); tick(); tick();
    memValid = 1'b0; tick();

    // Randomized traffic, including counter wraparound and occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      memValid  = ($urandom_range(0, 3) != 0);
      memData   = $urandom;
      stall     = ($urandom_range(0, 4) == 0);
      nextState = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b0; stall = 1'b0; memValid = 1'b0; nextState = 2'd0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Upstream control stage for the multi-cycle LEGv8 core. Fetches a 32-bit instruction from instruction memory over a valid/request handshake and holds it in an instruction register. Presents `instruction` and a 2-bit micro-`state` to the per-class decoders (I-arithmetic, R-type, load/store, branch), which return `nextState`. Steps through micro-states until a decoder returns state 0, then fetches the next instruction. A step watchdog and a retired-instruction counter are included.

Parameters:
COUNT_WIDTH, 16, width of the retired-instruction counter `instrCount`.
MAX_STEPS, 4, maximum micro-steps per instruction before the watchdog aborts it (legal range 1..4).

Ports:
clock  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
memRequest  output  1  instruction-memory read request.
memValid  input  1  memData holds the fetched word this cycle.
memData  input  32  fetched instruction word.
instruction  output  32  instruction register, to decoders.
state  output  2  current micro-state, to decoders.
nextState  input  2  micro-state requested by the active decoder.
stall  input  1  datapath hold; freezes execution.
execValid  output  1  the decoder control word is live this cycle.
instrCount  output  COUNT_WIDTH  retired-instruction count.
stepError  output  1  sticky flag: watchdog fired.

Behaviour:
- Phases: IDLE, FETCH, EXEC. Phase is internal; it is encoded by memRequest and execValid.
- Reset (any cycle, including mid-fetch or mid-execute), with the value at the first edge with reset=1:
  - phase=IDLE, instruction=0, state=0, stepCount=0, instrCount=0, stepError=0.
  - memRequest=0 and execValid=0 for the whole cycle.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH:
  - memRequest=1, execValid=0.
  - Wait states are unbounded; stay in FETCH while memValid=0.
  - On memValid=1: instruction<=memData, state<=0, stepCount<=0, phase<=EXEC.
- EXEC:
  - execValid=1, memRequest=0. memValid is ignored.
  - stall=1: instruction, state, stepCount and counters hold. execValid stays 1.
  - stall=0 and nextState!=0 and stepCount<MAX_STEPS-1: state<=nextState, stepCount++.
  - stall=0 and nextState==0: instruction retires. instrCount++ (wraps modulo 2^COUNT_WIDTH), state<=0, phase<=FETCH.
  - stall=0 and nextState!=0 and stepCount==MAX_STEPS-1: watchdog fires.
    - stepError<=1 (sticky until reset).
    - state<=0, phase<=FETCH.
    - instrCount does not increment.
- Timing:
  - Fetch-to-execute latency is 1 cycle after the accepting memValid edge.
  - A single-step instruction with no stall and zero-wait memory takes 2 cycles (FETCH, EXEC).
  - An N-step instruction takes 1+N cycles.
- All outputs are registered except memRequest and execValid, which are decoded from the phase register (plus nextState when PREFETCH_EN is defined).

Optional Feature:
Macro: PREFETCH_EN.
- Defined:
  - In EXEC, memRequest=1 also in any cycle with stall=0 and nextState==0 (the retiring step).
  - If memValid=1 in that cycle: instruction<=memData, state<=0, stepCount<=0, instrCount++, and phase stays EXEC. Back-to-back single-step instructions then sustain one per cycle.
  - If memValid=0: phase<=FETCH as normal.
  - A watchdog abort never prefetches.
- Not defined: memRequest is asserted only in FETCH, and the behaviour is exactly as above.

Test Plan:
1. Reset then ADDI X1,X1,#1: reset 2 cycles, then memValid=1, memData=0x91000421 in the first FETCH cycle; decoder nextState=0 -> next cycle instruction=0x91000421, state=0, execValid=1; following cycle memRequest=1 and instrCount=1.
2. Wait states: memValid held 0 for 3 FETCH cycles, then 1 with 0xD1000842 -> memRequest stays 1 for 4 cycles; instruction updates only on the 4th edge; execValid rises the cycle after.
3. Multi-step plus stall: nextState sequence 2,3,0 with stall=1 in the state=2 cycle for 2 cycles -> state reads 0,2,2,2,3; instrCount increments exactly once; total EXEC cycles = 5.
4. Watchdog (MAX_STEPS=4): nextState forced to 1 continuously -> after 4 EXEC cycles stepError=1, state=0, phase FETCH; instrCount unchanged; stepError stays 1 through the next normal instruction.
5. Reset mid-EXEC at state=2 with instrCount=5 -> next cycle instruction=0, state=0, instrCount=0, stepError=0, execValid=0, memRequest=0; memRequest=1 one cycle after reset deasserts.
6. PREFETCH_EN: memValid held 1 with words 0x91000421, 0x91000842, 0x91000C63 and nextState=0 -> execValid continuously 1; instruction changes every cycle; instrCount increments every cycle (1, 2, 3). Without the macro, the same stimulus yields one instruction per 2 cycles.
